// File: rtl/eee_hsmooth.sv
// eee_hsmooth: Avalon-ST video stage applying a per-channel horizontal
// 1-2-1 smoothing filter to video packets. Descriptor beats and non-video
// packets pass through unchanged. The mode conduit (1 = filter, 0 = bypass)
// is latched on every start-of-packet beat.
//
// Build option: define EEE_HSMOOTH_ROUND_EN to round half-up (+2 before the
// shift); leave it undefined for a truncating filter.
module eee_hsmooth #(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        mode
);

`ifdef EEE_HSMOOTH_ROUND_EN
  localparam logic [9:0] RND = 10'd2;
`else
  localparam logic [9:0] RND = 10'd0;
`endif

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    VIDEO = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [10:0] r_x;
  logic [23:0] r_left;
  logic [23:0] r_held;
  logic        r_held_eop;
  logic        r_filt_en;

  logic [23:0] r_src_data;
  logic        r_src_valid;
  logic        r_src_sop;
  logic        r_src_eop;

  logic        w_out_free;
  logic        w_accept;
  logic        w_is_video;
  logic        w_line_end;
  logic        w_start;
  logic        w_pixel;
  logic        w_flush;
  logic [23:0] w_f_run;
  logic [23:0] w_f_flush;

  // (L + 2C + R + RND) >> 2 per 8-bit channel; 10 bits hold the worst case
  // 255*4 + 2 = 1022, so the shifted result always fits in 8 bits.
  function automatic logic [23:0] filt(input logic [23:0] l,
                                       input logic [23:0] c,
                                       input logic [23:0] r);
    logic [23:0] res;
    logic [9:0]  sum;
    res = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      sum = {2'b00, l[8*ch +: 8]} + {1'b0, c[8*ch +: 8], 1'b0}
          + {2'b00, r[8*ch +: 8]} + RND;
      res[8*ch +: 8] = sum[9:2];
    end
    return res;
  endfunction

  assign w_out_free = ~r_src_valid | source_ready;
  assign sink_ready = w_out_free & (r_state != FLUSH);
  assign w_accept   = sink_valid & sink_ready;
  assign w_is_video = (sink_data[3:0] == 4'd0);
  assign w_line_end = (r_x == IMAGE_W - 11'd1) | sink_eop;

  // Any accepted beat in PASS, or an sop beat in VIDEO (truncated frame),
  // is forwarded unchanged; a non-sop beat in VIDEO is a pixel.
  assign w_start = w_accept & ((r_state == PASS) | sink_sop);
  assign w_pixel = w_accept & ~sink_sop & (r_state == VIDEO) & r_filt_en;
  assign w_flush = (r_state == FLUSH) & w_out_free;

  assign w_f_run   = filt(r_left, r_held, sink_data);
  assign w_f_flush = filt(r_left, r_held, r_held);

  assign source_data  = r_src_data;
  assign source_valid = r_src_valid;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;

  // Control FSM, line buffer (left/held pixels) and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PASS;
      r_x         <= '0;
      r_left      <= '0;
      r_held      <= '0;
      r_held_eop  <= 1'b0;
      r_filt_en   <= 1'b0;
      r_src_data  <= '0;
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
    end else begin
      // A consumed or empty output slot goes empty unless refilled below.
      if (w_out_free) begin
        r_src_valid <= 1'b0;
      end

      if (w_start) begin
        r_src_data  <= sink_data;
        r_src_valid <= 1'b1;
        r_src_sop   <= sink_sop;
        r_src_eop   <= sink_eop;
        if (sink_sop) begin
          // A new packet discards whatever pixel was held from a cut frame.
          r_filt_en <= mode;
          r_x       <= '0;
          r_state   <= (w_is_video & mode) ? VIDEO : PASS;
        end
      end else if (w_pixel) begin
        if (r_x != '0) begin
          r_src_data  <= w_f_run;
          r_src_valid <= 1'b1;
          r_src_sop   <= 1'b0;
          r_src_eop   <= 1'b0;
          r_left      <= r_held;
        end else begin
          // First pixel of a line replicates itself as the left neighbour.
          r_left <= sink_data;
        end
        r_held <= sink_data;
        if (w_line_end) begin
          // x restarts at 0 both on the natural wrap and on an early eop.
          r_state    <= FLUSH;
          r_held_eop <= sink_eop;
          r_x        <= '0;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end else if (w_flush) begin
        // Last pixel of the line: right neighbour replicated.
        r_src_data  <= w_f_flush;
        r_src_valid <= 1'b1;
        r_src_sop   <= 1'b0;
        r_src_eop   <= r_held_eop;
        r_x         <= '0;
        r_state     <= r_held_eop ? PASS : VIDEO;
      end
    end
  end

endmodule

// File: tb/tb_eee_hsmooth.sv
// Self-checking bench for eee_hsmooth (IMAGE_W = 8): table-driven line
// vectors plus hand-written sequences, checked through an expected-beat queue.
module tb_eee_hsmooth;

  localparam int W = 8;

`ifdef EEE_HSMOOTH_ROUND_EN
  localparam int          RND      = 2;
  localparam logic [23:0] IMP_SIDE = 24'h400000;
  localparam logic [23:0] IMP_MID  = 24'h800000;
`else
  localparam int          RND      = 0;
  localparam logic [23:0] IMP_SIDE = 24'h3F0000;
  localparam logic [23:0] IMP_MID  = 24'h7F0000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        mode;
  logic        bp_en = 1'b0;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic        e;
  } beat_t;

  typedef struct {
    logic [23:0] px [W];
    logic [23:0] ex [W];
  } vec_t;

  beat_t       q [$];
  beat_t       mon_e;
  logic [23:0] pix [$];
  vec_t        tab [4];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] data_prev = '0;

  eee_hsmooth #(.IMAGE_W(11'd8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  // Downstream readiness: toggles every cycle when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    source_ready = bp_en ? ~source_ready : 1'b1;
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic [23:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d;
    b.s = s;
    b.e = e;
    return b;
  endfunction

  // Reference 1-2-1 filter, computed channel by channel in integers.
  function automatic logic [23:0] f3(input logic [23:0] l, input logic [23:0] c,
                                     input logic [23:0] r);
    logic [23:0] o;
    int          s;
    o = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(l[8*ch +: 8]) + 2 * int'(c[8*ch +: 8]) + int'(r[8*ch +: 8]) + RND;
      o[8*ch +: 8] = 8'(s / 4);
    end
    return o;
  endfunction

  // Expected beats for a packet made of desc followed by pix[].
  task automatic push_model(input logic [23:0] desc, input logic filt);
    int          n;
    logic [23:0] l;
    logic [23:0] r;
    n = pix.size();
    q.push_back(mk(desc, 1'b1, 1'b0));
    for (int i = 0; i < n; i++) begin
      if (filt) begin
        l = ((i % W) == 0)     ? pix[i] : pix[i-1];
        r = ((i % W) == W - 1) ? pix[i] : pix[i+1];
        q.push_back(mk(f3(l, pix[i], r), 1'b0, i == n - 1));
      end else begin
        q.push_back(mk(pix[i], 1'b0, i == n - 1));
      end
    end
  endtask

  // Drive one beat from a negedge; returns on the negedge after acceptance.
  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int unsigned n;
    n = 0;
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_valid = 1'b1;
    while (!sink_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got sink_ready 0 expected 1");
    end
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] desc, input logic m, input logic flip_mode);
    mode = m;
    send(desc, 1'b1, 1'b0);
    if (flip_mode) mode = ~m;
    for (int i = 0; i < pix.size(); i++) send(pix[i], 1'b0, i == pix.size() - 1);
    mode = m;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 24'(q.size()), 24'd0);
    q.delete();
  endtask

  // Output monitor: pops the scoreboard on each consumed beat and checks
  // that a stalled beat stays put.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 24'(source_valid), 24'd1);
        chk("stall_data", source_data, data_prev);
      end
      if (source_valid && source_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL extra_beat: got %h expected no beat", source_data);
        end else begin
          mon_e = q.pop_front();
          chk("out_data", source_data, mon_e.d);
          chk("out_sop", 24'(source_sop), 24'(mon_e.s));
          chk("out_eop", 24'(source_eop), 24'(mon_e.e));
        end
      end
      stall_prev = source_valid & ~source_ready;
      data_prev  = source_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    sink_valid = 1'b0;
    sink_data  = '0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    mode       = 1'b0;

    tab[0].px = '{default: 24'h404040};
    tab[0].ex = '{default: 24'h404040};
    tab[1].px = '{24'h0, 24'h0, 24'h0, 24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0};
    tab[1].ex = '{24'h0, 24'h0, IMP_SIDE, IMP_MID, IMP_SIDE, 24'h0, 24'h0, 24'h0};
    tab[2].px = '{24'h000080, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    tab[2].ex = '{24'h000060, 24'h000020, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    tab[3].px = '{24'h000000, 24'h040404, 24'h080808, 24'h0C0C0C,
                  24'h101010, 24'h141414, 24'h181818, 24'h1C1C1C};
    tab[3].ex = '{24'h010101, 24'h040404, 24'h080808, 24'h0C0C0C,
                  24'h101010, 24'h141414, 24'h181818, 24'h1B1B1B};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 24'(source_valid), 24'd0);
    chk("rst_data", source_data, 24'd0);
    chk("rst_sop", 24'(source_sop), 24'd0);
    chk("rst_eop", 24'(source_eop), 24'd0);
    chk("rst_ready", 24'(sink_ready), 24'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single-line video packets
    for (int t = 0; t < 4; t++) begin
      pix.delete();
      q.push_back(mk(24'hA55A00, 1'b1, 1'b0));
      for (int x = 0; x < W; x++) begin
        pix.push_back(tab[t].px[x]);
        q.push_back(mk(tab[t].ex[x], 1'b0, x == W - 1));
      end
      send_frame(24'hA55A00, 1'b1, 1'b0);
      drain();
    end

    // Flat two-line frame: eop only on the 16th pixel
    pix.delete();
    q.push_back(mk(24'h123450, 1'b1, 1'b0));
    for (int i = 0; i < 2 * W; i++) begin
      pix.push_back(24'h404040);
      q.push_back(mk(24'h404040, 1'b0, i == 2 * W - 1));
    end
    send_frame(24'h123450, 1'b1, 1'b0);
    drain();

    // Bypass: each beat appears one cycle after acceptance, unchanged
    pix.delete();
    for (int i = 0; i < W; i++) pix.push_back(24'($urandom));
    push_model(24'h000000, 1'b0);
    mode = 1'b0;
    send(24'h000000, 1'b1, 1'b0);
    chk("byp_lat_valid", 24'(source_valid), 24'd1);
    for (int i = 0; i < W; i++) begin
      send(pix[i], 1'b0, i == W - 1);
      chk("byp_lat_data", source_data, pix[i]);
    end
    drain();

    // Non-video descriptor with filtering requested: passes through
    pix.delete();
    for (int i = 0; i < 5; i++) pix.push_back(24'($urandom));
    push_model(24'h00000F, 1'b0);
    send_frame(24'h00000F, 1'b1, 1'b0);
    drain();

    // Backpressure over a 2-line random frame; mode flips mid-packet
    pix.delete();
    for (int i = 0; i < 2 * W; i++) pix.push_back(24'($urandom));
    push_model(24'h777770, 1'b1);
    bp_en = 1'b1;
    send_frame(24'h777770, 1'b1, 1'b1);
    drain();
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Truncated frame: new sop after 3 pixels discards the held pixel
    pix.delete();
    for (int i = 0; i < 3; i++) pix.push_back(24'($urandom));
    q.push_back(mk(24'h111110, 1'b1, 1'b0));
    q.push_back(mk(f3(pix[0], pix[0], pix[1]), 1'b0, 1'b0));
    q.push_back(mk(f3(pix[0], pix[1], pix[2]), 1'b0, 1'b0));
    mode = 1'b1;
    send(24'h111110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(pix[i], 1'b0, 1'b0);
    pix.delete();
    for (int i = 0; i < W; i++) pix.push_back(24'($urandom));
    push_model(24'h222220, 1'b1);
    send_frame(24'h222220, 1'b1, 1'b0);
    drain();

    // Reset mid-frame at pixel 5
    pix.delete();
    for (int i = 0; i < W; i++) pix.push_back(24'($urandom));
    q.push_back(mk(24'h333330, 1'b1, 1'b0));
    q.push_back(mk(f3(pix[0], pix[0], pix[1]), 1'b0, 1'b0));
    for (int i = 1; i < 4; i++) q.push_back(mk(f3(pix[i-1], pix[i], pix[i+1]), 1'b0, 1'b0));
    mode = 1'b1;
    send(24'h333330, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(pix[i], 1'b0, 1'b0);
    sink_data  = pix[5];
    sink_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_mid_pre_valid", 24'(source_valid), 24'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 24'(source_valid), 24'd0);
    chk("rst_mid_data", source_data, 24'd0);
    chk("rst_mid_queue", 24'(q.size()), 24'd0);
    sink_valid = 1'b0;
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 24'(sink_ready), 24'd1);
    pix.delete();
    q.push_back(mk(24'hA55A00, 1'b1, 1'b0));
    for (int x = 0; x < W; x++) begin
      pix.push_back(tab[1].px[x]);
      q.push_back(mk(tab[1].ex[x], 1'b0, x == W - 1));
    end
    send_frame(24'hA55A00, 1'b1, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eee_hsmooth.md
# eee_hsmooth

Avalon-ST video stage placed directly upstream of the image processor, between the camera/VIP pipeline and the colour-detection block. In video packets it applies a per-channel horizontal 1-2-1 smoothing filter, which suppresses single-pixel sensor noise before red detection and bounding-box extraction. The packet descriptor beat and all non-video packets pass through unmodified. The `mode` conduit selects filtering or bypass; it is latched once per packet.

## Interface
- `IMAGE_W`, 11'd640: active pixels per line; used to find line ends.
- `clk`  in  1: system clock. One clock domain only.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sink_data`  in  24: pixel {R,G,B}, 8 bits each.
- `sink_valid`  in  1: sink beat valid.
- `sink_ready`  out  1: block can accept a sink beat.
- `sink_sop`, `sink_eop`  in  1 each: packet start / end.
- `source_data`  out  24: output pixel or beat.
- `source_valid`  out  1: source beat valid.
- `source_ready`  in  1: downstream accepts.
- `source_sop`, `source_eop`  out  1 each: packet start / end.
- `mode`  in  1: 1 = filter video, 0 = bypass.

## Operation
- Handshakes: a sink beat is accepted when `sink_valid & sink_ready`. A source beat is consumed when `source_valid & source_ready`.
- Output register: a single stage holds `source_*`. `out_free = ~source_valid | source_ready`.
- Ready rule: `sink_ready = out_free & (state != FLUSH)`. `sink_ready` does not depend on `sink_valid`.
- State PASS (reset state):
  - Every accepted beat is copied to the output register.
  - An accepted sop beat sets `video = (sink_data[3:0] == 0)` and latches `mode` into `filt_en`.
  - If `video & filt_en`, go to VIDEO with x = 0. Otherwise stay in PASS until eop.
- State VIDEO, on an accepted pixel P at column x:
  - x == 0: `held = P`, `left = P`. No output beat.
  - x > 0: emit `f(left, held, P)`, then `left = held`, `held = P`.
  - If x == IMAGE_W-1 or `sink_eop`: go to FLUSH and record `held_eop = sink_eop`.
  - x increments and wraps to 0 after IMAGE_W-1.
- State FLUSH: `sink_ready` = 0.
  - When `out_free`, emit `f(left, held, held)` with `source_eop = held_eop`.
  - Then go to PASS if `held_eop`, otherwise back to VIDEO with x = 0.
- Filter `f(L,C,R)`: per channel, `(L + 2C + R [+2]) >> 2` with a 10-bit intermediate; the result never exceeds 255. Left/right edge pixels are replicated.
- `source_sop` is asserted only on the passed-through descriptor beat. Filtered pixels carry sop = 0.
- Unexpected sop in VIDEO (truncated frame): any held pixel is discarded, the beat is handled as a new packet start, and the state goes to PASS/VIDEO by the rules above.
- A `mode` change mid-packet has no effect until the next sop.

## Timing
- Reset values: `source_valid` = 0, `source_data` = 0, `source_sop` = 0, `source_eop` = 0, state = PASS, x = 0, `filt_en` = 0. `sink_ready` is 1 after reset.
- Reset mid-packet clears the outputs immediately. The stream restarts at the next sop.
- Bypass and non-video beats: 1-cycle latency, full throughput.
- Filtered pixels at x < IMAGE_W-1: appear one cycle after pixel x+1 is accepted.
- Last pixel of each line: appears two cycles after its acceptance when not stalled.
- Filtering costs exactly one input bubble per line, caused by the FLUSH cycle.
- Backpressure: the output register holds its value while `source_valid & ~source_ready`. No beat is lost or duplicated.

## Configuration
- `EEE_HSMOOTH_ROUND_EN` defined: the filter adds +2 before the shift (round-half-up).
- `EEE_HSMOOTH_ROUND_EN` undefined: no +2; the result is truncated. All other behaviour is identical.

## Test plan
- Flat frame: `mode`=1, IMAGE_W=8, 2 lines of 0x404040. Output is 16 pixels of 0x404040, with eop on the 16th only and the descriptor beat unchanged.
- Impulse: line 0, x=3 = 0xFF0000, all other pixels 0.
  - ROUND_EN: x2 = 0x400000, x3 = 0x800000, x4 = 0x400000.
  - Without ROUND_EN: 0x3F0000, 0x7F0000, 0x3F0000.
- Edge replication: x0 = 0x000080, rest of the line 0. Output x0 = 0x000060 (ROUND) / 0x000060 (truncated); x1 = 0x000020.
- Bypass and non-video: `mode`=0 gives output equal to input with 1-cycle latency. A packet with descriptor `sink_data[3:0]` = 0xF and `mode`=1 is also passed through unchanged.
- Backpressure: `source_ready` toggles 1/0 every cycle over a 2-line frame. The output sequence is identical to the unstalled run, and `source_data` is stable while stalled.
- Reset mid-frame: assert `reset_n`=0 at pixel 5. `source_valid` drops with no clock edge. A new frame after release is filtered correctly from x=0.
